// File: rtl/ball_ctrl.sv
// ball_ctrl: per-frame ball motion with perimeter-wall reflection and a registered ball raster bit.
module ball_ctrl #(
    parameter int BALL_SIZE = 8,
    parameter int STEP      = 2,
    parameter int X_LO      = 16,
    parameter int X_HI      = 624,
    parameter int Y_LO      = 16,
    parameter int Y_HI      = 464
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] line,
    input  logic [9:0] pixel,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       BallRaster,
    output logic       hit_x,
    output logic       hit_y,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_STEP_X, S_STEP_Y, S_COMMIT} state_t;
    localparam logic [9:0] X_SERVE = 10'd316;
    localparam logic [8:0] Y_SERVE = 9'd236;
    state_t      state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d, nx_q, nx_d, x_nxt;
    logic [8:0]  ball_y_q, ball_y_d, ny_q, ny_d, y_nxt;
    logic        dx_q, dx_d, dy_q, dy_d, fx_q, fx_d, fy_q, fy_d;
    logic        hit_x_q, hit_x_d, hit_y_q, hit_y_d, raster_q, raster_d;
    logic [10:0] x_inc, y_inc;
    logic        x_over, x_under, x_hit, y_over, y_under, y_hit;
    // 11-bit intermediates keep the overrun tests free of wrap-around.
    assign x_inc   = 11'(ball_x_q) + 11'(STEP);
    assign x_over  = x_inc + 11'(BALL_SIZE - 1) > 11'(X_HI);
    assign x_under = 11'(ball_x_q) < 11'(X_LO + STEP);
    assign x_hit   = dx_q ? x_over : x_under;
    assign x_nxt   = dx_q ? (x_over ? 10'(X_HI - BALL_SIZE + 1) : x_inc[9:0])
                          : (x_under ? 10'(X_LO) : ball_x_q - 10'(STEP));
    assign y_inc   = 11'(ball_y_q) + 11'(STEP);
    assign y_over  = y_inc + 11'(BALL_SIZE - 1) > 11'(Y_HI);
    assign y_under = 11'(ball_y_q) < 11'(Y_LO + STEP);
    assign y_hit   = dy_q ? y_over : y_under;
    assign y_nxt   = dy_q ? (y_over ? 9'(Y_HI - BALL_SIZE + 1) : y_inc[8:0])
                          : (y_under ? 9'(Y_LO) : ball_y_q - 9'(STEP));
    assign raster_d = 11'(pixel) >= 11'(ball_x_q) && 11'(pixel) <= 11'(ball_x_q) + 11'(BALL_SIZE - 1) &&
                      11'(line) >= 11'(ball_y_q) && 11'(line) <= 11'(ball_y_q) + 11'(BALL_SIZE - 1);
    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        hit_x_d  = 1'b0;
        hit_y_d  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = (frame_tick && run) ? S_STEP_X : S_IDLE;
            S_STEP_X: begin
                nx_d    = x_nxt;
                fx_d    = x_hit;
                state_d = S_STEP_Y;
            end
            S_STEP_Y: begin
                ny_d    = y_nxt;
                fy_d    = y_hit;
                state_d = S_COMMIT;
            end
            default: begin
                ball_x_d = nx_q;
                ball_y_d = ny_q;
                dx_d     = dx_q ^ fx_q;
                dy_d     = dy_q ^ fy_q;
                hit_x_d  = fx_q;
                hit_y_d  = fy_q;
                fx_d     = 1'b0;
                fy_d     = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
        if (serve) begin
            state_d  = S_IDLE;
            ball_x_d = X_SERVE;
            ball_y_d = Y_SERVE;
            dx_d     = 1'b1;
            dy_d     = 1'b1;
            fx_d     = 1'b0;
            fy_d     = 1'b0;
            hit_x_d  = 1'b0;
            hit_y_d  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ball_x_q <= X_SERVE;
            ball_y_q <= Y_SERVE;
            nx_q     <= X_SERVE;
            ny_q     <= Y_SERVE;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            fx_q     <= 1'b0;
            fy_q     <= 1'b0;
            hit_x_q  <= 1'b0;
            hit_y_q  <= 1'b0;
            raster_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            hit_x_q  <= hit_x_d;
            hit_y_q  <= hit_y_d;
            raster_q <= raster_d;
        end
    end
    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign BallRaster = raster_q;
    assign hit_x      = hit_x_q;
    assign hit_y      = hit_y_q;
    assign busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed bench for ball_ctrl; a second instance with a narrower field reaches a corner quickly.
module tb_ball_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, frame_tick, run, serve;
    logic [8:0] line;
    logic [9:0] pixel;
    logic [9:0] ball_x, ball_x2;
    logic [8:0] ball_y, ball_y2;
    logic       BallRaster, hit_x, hit_y, busy;
    logic       BallRaster2, hit_x2, hit_y2, busy2;
    int         pass_cnt = 0;
    int         chk_cnt = 0;
    always #5 clk = ~clk;
    ball_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .line(line), .pixel(pixel), .frame_tick(frame_tick),
        .run(run), .serve(serve), .ball_x(ball_x), .ball_y(ball_y), .BallRaster(BallRaster),
        .hit_x(hit_x), .hit_y(hit_y), .busy(busy)
    );
    // Right wall at 544: clamp column 537 is hit on frame 111, the same frame as the bottom wall.
    ball_ctrl #(.X_HI(544)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .line(line), .pixel(pixel), .frame_tick(frame_tick),
        .run(run), .serve(serve), .ball_x(ball_x2), .ball_y(ball_y2), .BallRaster(BallRaster2),
        .hit_x(hit_x2), .hit_y(hit_y2), .busy(busy2)
    );
    task automatic frame_go();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask
    task automatic do_serve();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++; if (ball_x !== 10'd316) $display("FAIL rst_ball_x got %0d exp 316", ball_x); else pass_cnt++;
        chk_cnt++; if (ball_y !== 9'd236) $display("FAIL rst_ball_y got %0d exp 236", ball_y); else pass_cnt++;
        chk_cnt++; if ({busy, hit_x, hit_y, BallRaster} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {busy, hit_x, hit_y, BallRaster}); else pass_cnt++;
        @(negedge clk) begin rst_n = 1'b1; pixel = 10'd316; line = 9'd236; end
        @(negedge clk) pixel = 10'd323;
        chk_cnt++; if (BallRaster !== 1'b1) $display("FAIL raster_tl got %b exp 1", BallRaster); else pass_cnt++;
        @(negedge clk) pixel = 10'd324;
        chk_cnt++; if (BallRaster !== 1'b1) $display("FAIL raster_right_edge got %b exp 1", BallRaster); else pass_cnt++;
        @(negedge clk) begin pixel = 10'd316; line = 9'd244; end
        chk_cnt++; if (BallRaster !== 1'b0) $display("FAIL raster_past_right got %b exp 0", BallRaster); else pass_cnt++;
        @(negedge clk) begin pixel = 10'd315; line = 9'd236; end
        chk_cnt++; if (BallRaster !== 1'b0) $display("FAIL raster_past_bottom got %b exp 0", BallRaster); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (BallRaster !== 1'b0) $display("FAIL raster_before_left got %b exp 0", BallRaster); else pass_cnt++;
        frame_go();
        pixel = 10'd318;
        line  = 9'd238;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({busy, BallRaster} !== 2'b11) $display("FAIL pre_reset_busy_raster got %b exp 11", {busy, BallRaster}); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({busy, BallRaster, hit_x, hit_y} !== 4'b0) $display("FAIL midcycle_reset_flags got %b exp 0000", {busy, BallRaster, hit_x, hit_y}); else pass_cnt++;
        chk_cnt++; if ({ball_x, ball_y} !== {10'd316, 9'd236}) $display("FAIL midcycle_reset_pos got %0d,%0d exp 316,236", ball_x, ball_y); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
    endtask
    task automatic test_one_frame();
        @(negedge clk) frame_tick = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk) frame_tick = 1'b0;
            chk_cnt++; if (busy !== 1'b1) $display("FAIL frame_busy_t%0d got %b exp 1", i, busy); else pass_cnt++;
            chk_cnt++; if (ball_x !== 10'd316) $display("FAIL frame_hold_t%0d got %0d exp 316", i, ball_x); else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL frame_busy_t4 got %b exp 0", busy); else pass_cnt++;
        chk_cnt++; if ({ball_x, ball_y} !== {10'd318, 9'd238}) $display("FAIL frame_pos got %0d,%0d exp 318,238", ball_x, ball_y); else pass_cnt++;
        chk_cnt++; if ({hit_x, hit_y} !== 2'b00) $display("FAIL frame_hits got %b exp 00", {hit_x, hit_y}); else pass_cnt++;
    endtask
    task automatic test_busy_ignore();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) begin frame_tick = 1'b1; run = 1'b0; end
        @(negedge clk) frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if ({ball_x, ball_y} !== {10'd320, 9'd240}) $display("FAIL runfall_pos got %0d,%0d exp 320,240", ball_x, ball_y); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL retick_busy got %b exp 0", busy); else pass_cnt++;
        run = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({busy, ball_x} !== {1'b0, 10'd320}) $display("FAIL retick_after got %b,%0d exp 0,320", busy, ball_x); else pass_cnt++;
    endtask
    task automatic test_serve_mid();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL serve_busy got %b exp 0", busy); else pass_cnt++;
        chk_cnt++; if ({ball_x, ball_y} !== {10'd316, 9'd236}) $display("FAIL serve_pos got %0d,%0d exp 316,236", ball_x, ball_y); else pass_cnt++;
        repeat (2) @(negedge clk);
        chk_cnt++; if ({ball_x, ball_y, hit_x, hit_y, busy} !== {10'd316, 9'd236, 3'b000}) $display("FAIL serve_discard got %0d,%0d,%b%b%b exp 316,236,000", ball_x, ball_y, hit_x, hit_y, busy); else pass_cnt++;
        frame_go();
        chk_cnt++; if ({ball_x, ball_y} !== {10'd318, 9'd238}) $display("FAIL serve_next_pos got %0d,%0d exp 318,238", ball_x, ball_y); else pass_cnt++;
    endtask
    task automatic test_gating();
        do_serve();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            chk_cnt++; if (busy !== 1'b0) $display("FAIL gate_busy_%0d got %b exp 0", i, busy); else pass_cnt++;
        end
        @(negedge clk);
        chk_cnt++; if ({ball_x, ball_y} !== {10'd316, 9'd236}) $display("FAIL gate_pos got %0d,%0d exp 316,236", ball_x, ball_y); else pass_cnt++;
        run = 1'b1;
    endtask
    task automatic test_long_run();
        do_serve();
        for (int f = 1; f <= 152; f++) begin
            frame_go();
            chk_cnt++; if ({hit_x, hit_y} !== {1'(f == 151), 1'(f == 111)}) $display("FAIL run_hits_f%0d got %b%b", f, hit_x, hit_y); else pass_cnt++;
            if (f == 110) begin
                chk_cnt++; if (ball_y !== 9'd456) $display("FAIL run_y_f110 got %0d exp 456", ball_y); else pass_cnt++;
            end
            if (f == 111) begin
                chk_cnt++; if (ball_y !== 9'd457) $display("FAIL run_y_f111 got %0d exp 457", ball_y); else pass_cnt++;
            end
            if (f == 112) begin
                chk_cnt++; if (ball_y !== 9'd455) $display("FAIL run_y_f112 got %0d exp 455", ball_y); else pass_cnt++;
            end
            if (f == 150) begin
                chk_cnt++; if (ball_x !== 10'd616) $display("FAIL run_x_f150 got %0d exp 616", ball_x); else pass_cnt++;
            end
            if (f == 151) begin
                chk_cnt++; if ({ball_x, ball_y} !== {10'd617, 9'd377}) $display("FAIL run_pos_f151 got %0d,%0d exp 617,377", ball_x, ball_y); else pass_cnt++;
                @(negedge clk);
                chk_cnt++; if (hit_x !== 1'b0) $display("FAIL run_hitx_width got %b exp 0", hit_x); else pass_cnt++;
            end
            if (f == 152) begin
                chk_cnt++; if ({ball_x, ball_y} !== {10'd615, 9'd375}) $display("FAIL run_pos_f152 got %0d,%0d exp 615,375", ball_x, ball_y); else pass_cnt++;
            end
        end
    endtask
    task automatic test_corner();
        do_serve();
        for (int f = 1; f <= 112; f++) begin
            frame_go();
            if (f == 111) begin
                chk_cnt++; if ({hit_x2, hit_y2} !== 2'b11) $display("FAIL corner_hits got %b%b exp 11", hit_x2, hit_y2); else pass_cnt++;
                chk_cnt++; if ({ball_x2, ball_y2} !== {10'd537, 9'd457}) $display("FAIL corner_pos got %0d,%0d exp 537,457", ball_x2, ball_y2); else pass_cnt++;
            end
            if (f == 112) begin
                chk_cnt++; if ({hit_x2, hit_y2} !== 2'b00) $display("FAIL corner_after_hits got %b%b exp 00", hit_x2, hit_y2); else pass_cnt++;
                chk_cnt++; if ({ball_x2, ball_y2} !== {10'd535, 9'd455}) $display("FAIL corner_flip got %0d,%0d exp 535,455", ball_x2, ball_y2); else pass_cnt++;
            end
        end
    endtask
    initial begin
        rst_n      = 1'b1;
        frame_tick = 1'b0;
        run        = 1'b1;
        serve      = 1'b0;
        pixel      = '0;
        line       = '0;
        test_reset();
        test_one_frame();
        test_busy_ignore();
        test_serve_mid();
        test_gating();
        test_long_run();
        test_corner();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
